// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave transceiver: mode encodings, FSM states
// and the frame word-count width.
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam int WCNT_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, followed by one history flop
// so rise/fall are decoded from the last two stages of the chain.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {(STAGES + 1){RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-1:0], din};
        end
    end

    assign rise =  sync_q[STAGES-1] & ~sync_q[STAGES];
    assign fall = ~sync_q[STAGES-1] &  sync_q[STAGES];

endmodule

// File: rtl/spi_slave_xcvr.sv
// Full-duplex SPI slave, oversampled on clk: any CPOL/CPHA mode, WIDTH-bit words,
// selectable bit order, multi-word frames with abort and word-count reporting.
module spi_slave_xcvr
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             mosi,
    input  logic             cs_n,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_load,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_active,
    output logic             frame_abort,
    output logic [7:0]       word_count
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [1:0]     MODE  = 2'(((CPOL & 1) << 1) | (CPHA & 1));
    // Modes 0 and 3 sample on the rising sck edge, modes 1 and 2 on the falling one.
    localparam bit SAMPLE_ON_RISE = (MODE == MODE0) || (MODE == MODE3);

    function automatic logic tx_head(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] tx_adv(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [WIDTH-1:0] rx_ins(input logic [WIDTH-1:0] v, input logic b);
        return (LSB_FIRST != 0) ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
    endfunction

    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sck_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // mosi is taken from the same chain depth as the sck edge decode so they align.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    spi_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic             rx_vld_p1;
    logic             sample_edge, shift_edge;
    logic             do_start, do_stop, do_sample, do_shift, word_done, do_load;

    assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;

    assign do_start  = (state == IDLE) && cs_fall;
    assign do_stop   = (state == ACTIVE) && cs_rise;
    assign do_sample = (state == ACTIVE) && !cs_rise && sample_edge;
    // With CPHA=0 the next word's first bit is already on miso after a reload.
    assign do_shift  = (state == ACTIVE) && !cs_rise && shift_edge &&
                       ((CPHA != 0) || (bit_cnt != '0));
    assign word_done = do_sample && (bit_cnt == LAST);
    assign do_load   = do_start || word_done;
    assign rx_next   = rx_ins(rx_shift, mosi_s);

    // p0: edge decode above; p1: rx_data captured; p2: rx_valid presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            word_count   <= '0;
            frame_active <= 1'b0;
            miso_oe      <= 1'b0;
            miso         <= 1'b0;
            tx_load      <= 1'b0;
            frame_abort  <= 1'b0;
            rx_vld_p1    <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
        end else begin
            tx_load     <= do_load;
            frame_abort <= do_stop && (bit_cnt != '0);
            rx_vld_p1   <= word_done;
            rx_valid    <= rx_vld_p1;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state        <= ACTIVE;
                        bit_cnt      <= '0;
                        word_count   <= '0;
                        frame_active <= 1'b1;
                        miso_oe      <= 1'b1;
                        if (CPHA == 0) miso <= tx_head(tx_data);
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state        <= IDLE;
                        bit_cnt      <= '0;
                        frame_active <= 1'b0;
                        miso_oe      <= 1'b0;
                        miso         <= 1'b0;
                    end else begin
                        if (do_sample) begin
                            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                            if (word_done) begin
                                rx_data    <= rx_next;
                                word_count <= sat_inc(word_count);
                                if (CPHA == 0) miso <= tx_head(tx_data);
                            end
                        end
                        if (do_shift) miso <= tx_head(tx_shift);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_load) begin
            tx_shift <= (CPHA == 0) ? tx_adv(tx_data) : tx_data;
        end else if (do_shift) begin
            tx_shift <= tx_adv(tx_shift);
        end
        if (do_sample) rx_shift <= rx_next;
    end

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Directed bench for spi_slave_xcvr: three instances cover modes 0, 3 (16-bit
// LSB-first) and 1; a bit-banged master drives one instance at a time.
`timescale 1ns/1ps
module tb_spi_slave_xcvr;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  sck   = 3'b010;
    logic [2:0]  cs_n  = 3'b111;
    logic        mosi  = 1'b0;
    logic [15:0] tx_cur = 16'h0;
    logic [1:0]  sel   = 2'd0;

    logic [2:0]  miso_v, oe_v, ld_v, rv_v, fa_v, ab_v;
    logic [7:0]  rx0, rx2, wc0, wc1, wc2;
    logic [15:0] rx1;

    logic        m_miso, m_oe, m_ld, m_rv, m_fa, m_ab;
    logic [15:0] m_rx;
    logic [7:0]  m_wc;

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0, end_cyc = 0, last_lat = 0;
    int          rv_cnt = 0, ab_cnt = 0, ld_cnt = 0, tx_idx = 0;
    logic [15:0] rxq[$];
    logic [15:0] tx_tab [0:3];
    logic [15:0] mw [0:255];
    logic [15:0] mcap [0:3];

    always #5 clk = ~clk;

    spi_slave_xcvr #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2)) u_m0 (
        .clk(clk), .rst_n(rst_n), .sck(sck[0]), .mosi(mosi), .cs_n(cs_n[0]),
        .miso(miso_v[0]), .miso_oe(oe_v[0]), .tx_data(tx_cur[7:0]), .tx_load(ld_v[0]),
        .rx_data(rx0), .rx_valid(rv_v[0]), .frame_active(fa_v[0]),
        .frame_abort(ab_v[0]), .word_count(wc0));

    spi_slave_xcvr #(.WIDTH(16), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .SYNC_STAGES(2)) u_m3 (
        .clk(clk), .rst_n(rst_n), .sck(sck[1]), .mosi(mosi), .cs_n(cs_n[1]),
        .miso(miso_v[1]), .miso_oe(oe_v[1]), .tx_data(tx_cur), .tx_load(ld_v[1]),
        .rx_data(rx1), .rx_valid(rv_v[1]), .frame_active(fa_v[1]),
        .frame_abort(ab_v[1]), .word_count(wc1));

    spi_slave_xcvr #(.WIDTH(8), .CPOL(0), .CPHA(1), .LSB_FIRST(0), .SYNC_STAGES(2)) u_m1 (
        .clk(clk), .rst_n(rst_n), .sck(sck[2]), .mosi(mosi), .cs_n(cs_n[2]),
        .miso(miso_v[2]), .miso_oe(oe_v[2]), .tx_data(tx_cur[7:0]), .tx_load(ld_v[2]),
        .rx_data(rx2), .rx_valid(rv_v[2]), .frame_active(fa_v[2]),
        .frame_abort(ab_v[2]), .word_count(wc2));

    always_comb begin
        m_miso = miso_v[sel];
        m_oe   = oe_v[sel];
        m_ld   = ld_v[sel];
        m_rv   = rv_v[sel];
        m_fa   = fa_v[sel];
        m_ab   = ab_v[sel];
        m_rx   = {8'h0, rx0};
        m_wc   = wc0;
        case (sel)
            2'd1:    begin m_rx = rx1;          m_wc = wc1; end
            2'd2:    begin m_rx = {8'h0, rx2};  m_wc = wc2; end
            default: begin m_rx = {8'h0, rx0};  m_wc = wc0; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clk cycle; observe the selected instance on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (m_rv) begin
            rv_cnt++;
            rxq.push_back(m_rx);
            last_lat = cyc - end_cyc;
        end
        if (m_ab) ab_cnt++;
        if (m_ld) begin
            ld_cnt++;
            if (tx_idx < 3) tx_idx++;
            tx_cur = tx_tab[tx_idx];
        end
    endtask

    task automatic clr();
        rv_cnt = 0; ab_cnt = 0; ld_cnt = 0; tx_idx = 0;
        rxq.delete();
        tx_cur = tx_tab[0];
        for (int i = 0; i < 4; i++) mcap[i] = 16'h0;
    endtask

    function automatic logic [15:0] rxq_at(input int k);
        return (k < rxq.size()) ? rxq[k] : 16'hDEAD;
    endfunction

    // Master: nw words from mw[], last word cut after 'cut' bits when cut != 0.
    task automatic frame(input int nw, input int cut, input int hp);
        int nbits, nb;
        logic bv;
        logic [15:0] cap;
        nbits = (sel == 2'd1) ? 16 : 8;
        cs_n[sel] = 1'b0;
        repeat (6) tick();
        for (int w = 0; w < nw; w++) begin
            cap = 16'h0;
            nb  = (cut != 0 && w == nw - 1) ? cut : nbits;
            for (int b = 0; b < nb; b++) begin
                bv = (sel == 2'd1) ? mw[w][b] : mw[w][nbits-1-b];
                if (sel == 2'd0) begin
                    mosi = bv;
                    tick();
                    cap = {cap[14:0], m_miso};
                    sck[sel] = ~sck[sel];
                    if (b == nbits - 1) end_cyc = cyc;
                    repeat (hp) tick();
                    sck[sel] = ~sck[sel];
                    repeat (hp - 1) tick();
                end else begin
                    sck[sel] = ~sck[sel];
                    repeat (hp - 1) tick();
                    mosi = bv;
                    tick();
                    if (sel == 2'd1) cap[b] = m_miso;
                    else cap = {cap[14:0], m_miso};
                    sck[sel] = ~sck[sel];
                    if (b == nbits - 1) end_cyc = cyc;
                    repeat (hp) tick();
                end
            end
            if (w < 4) mcap[w] = cap;
        end
        repeat (hp + 4) tick();
        cs_n[sel] = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) tx_tab[i] = 16'h0;
        clr();
        repeat (3) tick();
        chk("rst_ctl", {m_miso, m_oe, m_ld, m_rv, m_fa, m_ab}, 0);
        chk("rst_rx", m_rx, 0);
        chk("rst_wc", m_wc, 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Mode 0: 0xA5 in, 0x3C out
        sel = 2'd0; tx_tab[0] = 16'h3C; clr();
        mw[0] = 16'hA5;
        frame(1, 0, 4);
        chk("m0_rx", m_rx, 16'hA5);
        chk("m0_rv", rv_cnt, 1);
        chk("m0_miso", mcap[0], 16'h3C);
        chk("m0_wc", m_wc, 1);
        chk("m0_load", ld_cnt, 2);
        chk("m0_abort", ab_cnt, 0);
        chk("m0_lat", last_lat, 4);
        chk("m0_idle", {m_oe, m_fa, m_miso}, 0);

        // Abort after 5 bits
        clr(); mw[0] = 16'hFF;
        frame(1, 5, 4);
        chk("ab_pulse", ab_cnt, 1);
        chk("ab_rv", rv_cnt, 0);
        chk("ab_rx", m_rx, 16'hA5);
        chk("ab_wc", m_wc, 0);

        // Mode 3, 16 bits LSB first
        sel = 2'd1; tx_tab[0] = 16'hC3A5; clr();
        mw[0] = 16'h1234;
        frame(1, 0, 4);
        chk("m3_rx", m_rx, 16'h1234);
        chk("m3_rv", rv_cnt, 1);
        chk("m3_miso", mcap[0], 16'hC3A5);
        chk("m3_load", ld_cnt, 2);
        chk("m3_wc", m_wc, 1);

        // Mode 1, three-word frame with tx_data advanced on each tx_load
        sel = 2'd2;
        tx_tab[0] = 16'hAA; tx_tab[1] = 16'h55; tx_tab[2] = 16'hF0; tx_tab[3] = 16'h00;
        clr();
        mw[0] = 16'h01; mw[1] = 16'h02; mw[2] = 16'h03;
        frame(3, 0, 4);
        chk("m1_rv", rv_cnt, 3);
        chk("m1_rx0", rxq_at(0), 16'h01);
        chk("m1_rx1", rxq_at(1), 16'h02);
        chk("m1_rx2", rxq_at(2), 16'h03);
        chk("m1_miso0", mcap[0], 16'hAA);
        chk("m1_miso1", mcap[1], 16'h55);
        chk("m1_miso2", mcap[2], 16'hF0);
        chk("m1_wc", m_wc, 3);
        chk("m1_load", ld_cnt, 4);

        // Mode 0 at sck = clk/4, 256 back-to-back words
        sel = 2'd0;
        for (int i = 0; i < 4; i++) tx_tab[i] = 16'h0;
        clr();
        for (int k = 0; k < 256; k++) mw[k] = 16'((k * 37 + 11) & 8'hFF);
        frame(256, 0, 2);
        begin
            int errs;
            errs = 0;
            for (int k = 0; k < 256; k++) if (rxq_at(k) !== mw[k]) errs++;
            chk("b2b_rv", rv_cnt, 256);
            chk("b2b_data_errs", errs, 0);
        end
        chk("b2b_wc_sat", m_wc, 255);
        chk("b2b_abort", ab_cnt, 0);

        // Asynchronous reset after 4 bits of a frame, then a clean 0x5A frame
        clr();
        cs_n[0] = 1'b0;
        repeat (6) tick();
        for (int b = 0; b < 4; b++) begin
            mosi = b[0];
            tick();
            sck[0] = 1'b1;
            repeat (4) tick();
            sck[0] = 1'b0;
            repeat (3) tick();
        end
        chk("mid_active", {m_fa, m_oe}, 2'b11);
        #1 rst_n = 1'b0;
        #2;
        chk("rst2_ctl", {m_miso, m_oe, m_ld, m_rv, m_fa, m_ab}, 0);
        chk("rst2_rx", m_rx, 0);
        chk("rst2_wc", m_wc, 0);
        cs_n[0] = 1'b1;
        mosi = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        clr(); mw[0] = 16'h5A;
        frame(1, 0, 4);
        chk("post_rx", m_rx, 16'h5A);
        chk("post_rv", rv_cnt, 1);
        chk("post_wc", m_wc, 1);
        chk("post_abort", ab_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_xcvr.md
Name: spi_slave_xcvr

Overview:
Parametrised full-duplex SPI slave, replacing the 8-bit receive-only SPI front end that feeds the VGA text-mode command path. Oversamples sck/cs_n/mosi on the system clock, supports all four CPOL/CPHA modes, configurable word width and bit order, and multi-word frames. Shifts a transmit word out on miso and reports frame events to the command decoder.

Parameters:
WIDTH, 8, bits per SPI word (2..32)
CPOL, 0, sck idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
LSB_FIRST, 0, 0 = MSB first on both mosi and miso
SYNC_STAGES, 2, synchroniser depth for sck, cs_n and mosi (>=2)

Ports:
clk  in  1  system clock, must be >= 4x sck
rst_n  in  1  asynchronous active-low reset
sck  in  1  SPI clock, asynchronous
mosi  in  1  SPI data in, asynchronous
cs_n  in  1  chip select, active-low, asynchronous
miso  out  1  SPI data out
miso_oe  out  1  miso output enable (1 while frame active)
tx_data  in  WIDTH  word to transmit
tx_load  out  1  1-cycle pulse: tx_data sampled into shifter this cycle
rx_data  out  WIDTH  last complete received word
rx_valid  out  1  1-cycle pulse: rx_data updated
frame_active  out  1  high between synchronised cs_n fall and rise
frame_abort  out  1  1-cycle pulse: cs_n rose with partial word pending
word_count  out  8  complete words in current frame, saturates at 255

Behaviour:
- Reset: all sync flops cleared (cs_n sync chain reset to 1, sck chain to CPOL); miso=0, miso_oe=0, tx_load=0, rx_data=0, rx_valid=0, frame_active=0, frame_abort=0, word_count=0, bit counter=0, state IDLE.
- Edge detect on the last two synchroniser stages; mosi uses the same depth so data aligns with the sck edge.
- Leading edge = sck leaves CPOL level; trailing edge = sck returns to it. Sample edge = leading if CPHA=0, else trailing; the other edge is the shift edge.
- FSM: IDLE -> ACTIVE on cs_n fall; ACTIVE -> IDLE on cs_n rise (takes priority over any same-cycle sck edge).
- On cs_n fall: tx_load pulses, tx_data is loaded, bit counter=0, word_count=0, frame_active=1, miso_oe=1. For CPHA=0 the first tx bit drives miso that same cycle; for CPHA=1 the first shift edge drives it.
- Sample edge in ACTIVE: shift mosi into rx shifter (at LSB end if LSB_FIRST=0, else MSB end); bit counter +1.
- On the WIDTH-th sample: rx_data <= completed word, rx_valid pulses the next cycle, word_count +1 (saturating), bit counter wraps to 0, tx_load pulses and tx_data reloads for the next word. With CPHA=0 the next word's first bit is presented immediately.
- Shift edge in ACTIVE: advance tx shifter; miso = next bit. For CPHA=0 the first shift edge after a reload is skipped.
- Sample edges outside ACTIVE are ignored. sck edges at cs_n fall are ignored that cycle.
- cs_n rise with bit counter != 0: frame_abort pulses, partial word discarded, rx_data unchanged, no rx_valid. With counter == 0: no pulse.
- On cs_n rise: miso_oe=0, miso=0, frame_active=0. word_count holds its value until the next cs_n fall.
- Latency from pin sck edge to rx_valid: SYNC_STAGES+2 clk cycles.
- Async reset mid-frame: everything returns to reset values. The next frame starts only on a fresh cs_n fall after reset release.

Decomposition:
- Package spi_pkg: SPI mode encoding constants (MODE0..MODE3 as {CPOL,CPHA}), FSM state typedef (IDLE, ACTIVE), word_count width constant.
- One sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall detect, instantiated for sck and cs_n. mosi uses the bare synchroniser path.

Test Plan:
- Mode 0, WIDTH=8: master sends 0xA5, tx_data=0x3C -> rx_data=0xA5 with one rx_valid; miso bits 0,0,1,1,1,1,0,0; word_count=1.
- Mode 3, WIDTH=16, LSB_FIRST=1: send 0x1234 LSB first -> rx_data=0x1234; tx_load pulses at cs_n fall and after word.
- Mode 1, WIDTH=8: 3-word frame 0x01,0x02,0x03, tx_data changed after each tx_load to 0xAA,0x55,0xF0 -> three rx_valid pulses in order, miso matches each word, word_count=3.
- Abort: mode 0 frame, cs_n rises after 5 bits -> frame_abort one pulse, no rx_valid, rx_data keeps previous 0xA5.
- Reset mid-frame after 4 bits, then a new 0x5A frame -> all outputs at reset values during reset; next frame yields rx_data=0x5A cleanly.
- sck at exactly clk/4 with back-to-back words -> no missed or duplicate samples; 256-word frame leaves word_count saturated at 255.
